mem_read_arbiter: RTL and testbench

Shares the single AXI4 read address/data channel between the instruction-cache refill path and the data-cache refill path. Accepts one line-fill request at a time from either cache, drives it on AR, and routes the single-beat 128-bit R response back to the requester. Arbitration is round-robin on simultaneous requests. The block sits between the cache miss logic and the top-level AXI master port.

---
 rtl/mem_read_arbiter_if.sv | 40 ++++
 rtl/mem_read_arbiter.sv | 98 +++++++++
 tb/tb_mem_read_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// Bundle of the two cache refill ports and the shared AXI read channel seen by mem_read_arbiter.
// master: arbiter side; slave: environment side (both caches plus the AXI slave).
interface mem_read_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128
);
  logic              ic_arvalid;
  logic [ADDR_W-1:0] ic_araddr;
  logic              ic_arready;
  logic              ic_rvalid;
  logic              ic_rready;
  logic              dc_arvalid;
  logic [ADDR_W-1:0] dc_araddr;
  logic              dc_arready;
  logic              dc_rvalid;
  logic              dc_rready;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;
  logic              busy;
  logic              grant_dc;

  modport master (
    input  ic_arvalid, ic_araddr, ic_rready, dc_arvalid, dc_araddr, dc_rready,
    input  ARREADY, RDATA, RVALID,
    output ic_arready, ic_rvalid, dc_arready, dc_rvalid, rdata,
    output ARADDR, ARVALID, RREADY, busy, grant_dc
  );

  modport slave (
    output ic_arvalid, ic_araddr, ic_rready, dc_arvalid, dc_araddr, dc_rready,
    output ARREADY, RDATA, RVALID,
    input  ic_arready, ic_rvalid, dc_arready, dc_rvalid, rdata,
    input  ARADDR, ARVALID, RREADY, busy, grant_dc
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one single-beat AXI4 read channel between I-cache and D-cache line refills.
// Round-robin on ties by default; define ARB_FIXED_PRIO_EN to make the D-cache win every tie.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_read_arbiter_if.master   bus
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_dc_q, grant_dc_d;
  logic              last_grant_q, last_grant_d;

  logic pick_dc_c;
  logic ic_arready_c, dc_arready_c;
  logic ic_rvalid_c, dc_rvalid_c;
  logic arvalid_c, rready_c;

  // Winner selection when the block is idle
`ifdef ARB_FIXED_PRIO_EN
  assign pick_dc_c = bus.dc_arvalid;
`else
  assign pick_dc_c = bus.dc_arvalid & (~bus.ic_arvalid | ~last_grant_q);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      grant_dc_q   <= 1'b1;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      grant_dc_q   <= grant_dc_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    grant_dc_d   = grant_dc_q;
    last_grant_d = last_grant_q;
    ic_arready_c = 1'b0;
    dc_arready_c = 1'b0;
    ic_rvalid_c  = 1'b0;
    dc_rvalid_c  = 1'b0;
    arvalid_c    = 1'b0;
    rready_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ic_arvalid || bus.dc_arvalid) begin
          ic_arready_c = ~pick_dc_c & resetn;
          dc_arready_c = pick_dc_c & resetn;
          addr_d       = (pick_dc_c ? bus.dc_araddr : bus.ic_araddr) & LINE_MASK;
          grant_dc_d   = pick_dc_c;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        arvalid_c = 1'b1;
        if (bus.ARREADY) state_d = DATA;
      end
      DATA: begin
        // Response handshake is a pure pass-through to the granted cache
        rready_c    = grant_dc_q ? bus.dc_rready : bus.ic_rready;
        ic_rvalid_c = ~grant_dc_q & bus.RVALID;
        dc_rvalid_c = grant_dc_q & bus.RVALID;
        if (bus.RVALID && rready_c) begin
          last_grant_d = grant_dc_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ic_arready = ic_arready_c;
  assign bus.dc_arready = dc_arready_c;
  assign bus.ic_rvalid  = ic_rvalid_c;
  assign bus.dc_rvalid  = dc_rvalid_c;
  assign bus.rdata      = DATA_W'(bus.RDATA);
  assign bus.ARADDR     = addr_q;
  assign bus.ARVALID    = arvalid_c;
  assign bus.RREADY     = rready_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_dc   = grant_dc_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: vector table of refill transactions plus
// hand-written tie, back-to-back and reset-during-DATA sequences, with a response scoreboard.
module tb_mem_read_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam logic [31:0] MASK   = 32'hFFFF_FFF0;

  typedef struct {
    logic         gdc;
    logic [31:0]  addr;
    logic [127:0] data;
  } sb_t;

  typedef struct {
    logic         ic_req;
    logic         dc_req;
    logic [31:0]  ic_addr;
    logic [31:0]  dc_addr;
    logic [127:0] rd;
    int           ar_dly;
    int           r_dly;
    logic         exp_gdc;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t vecs[8];

  mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tie winner: round-robin value, or always the D-cache in the fixed-priority build
  function automatic logic tie(input logic rr_gdc);
`ifdef ARB_FIXED_PRIO_EN
    return 1'b1 | rr_gdc;
`else
    return rr_gdc;
`endif
  endfunction

  // Scoreboard: pop on every completed response handshake
  always @(negedge clk) begin
    if (resetn === 1'b1 &&
        ((bus.ic_rvalid && bus.ic_rready) || (bus.dc_rvalid && bus.dc_rready))) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious_resp", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_resp_side_dc", bus.dc_rvalid, e.gdc);
        chk("sb_resp_side_ic", bus.ic_rvalid, !e.gdc);
        chk("sb_rdata", bus.rdata, e.data);
      end
    end
  end

  task automatic grant_check(input logic gdc, input logic [31:0] exp_addr, input logic [127:0] rd);
    sb_t e;
    @(negedge clk);
    chk("ic_arready_grant", bus.ic_arready, !gdc);
    chk("dc_arready_grant", bus.dc_arready, gdc);
    chk("busy_idle", bus.busy, 1'b0);
    e.gdc = gdc; e.addr = exp_addr; e.data = rd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Winner drops its request and moves its address; ARADDR must not follow
    if (gdc) begin bus.dc_arvalid = 1'b0; bus.dc_araddr = 32'h5A5A_5A5A; end
    else     begin bus.ic_arvalid = 1'b0; bus.ic_araddr = 32'hC3C3_C3C3; end
  endtask

  task automatic addr_phase(input int n, input logic [31:0] exp_addr);
    for (int i = 0; i <= n; i++) begin
      bus.ARREADY = (i == n);
      @(negedge clk);
      chk("arvalid_addr", bus.ARVALID, 1'b1);
      chk("araddr", bus.ARADDR, exp_addr);
      chk("arready_wait", bus.ic_arready | bus.dc_arready, 1'b0);
      chk("rready_addr", bus.RREADY, 1'b0);
      @(posedge clk); #1;
    end
    bus.ARREADY = 1'b0;
  endtask

  task automatic data_phase(input logic gdc, input int n, input logic [127:0] rd);
    bus.RVALID = 1'b1;
    bus.RDATA  = rd;
    for (int i = 0; i <= n; i++) begin
      if (gdc) begin bus.dc_rready = (i == n); bus.ic_rready = 1'b1; end
      else     begin bus.ic_rready = (i == n); bus.dc_rready = 1'b1; end
      @(negedge clk);
      chk("rready_track", bus.RREADY, (i == n));
      chk("arvalid_data", bus.ARVALID, 1'b0);
      chk("grant_dc", bus.grant_dc, gdc);
      chk("winner_rvalid", gdc ? bus.dc_rvalid : bus.ic_rvalid, 1'b1);
      chk("loser_rvalid", gdc ? bus.ic_rvalid : bus.dc_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    bus.RVALID    = 1'b0;
    bus.RDATA     = '1;
    bus.ic_rready = 1'b0;
    bus.dc_rready = 1'b0;
    chk("busy_after_txn", bus.busy, 1'b0);
  endtask

  initial begin
    logic        w;
    logic [31:0] a;

    vecs[0] = '{1, 1, 32'h1111_2227, 32'h2222_333C, {16{8'h0F}},  0, 0, tie(1'b0)};
    vecs[1] = '{1, 0, 32'h0000_1234, 32'h0,         {16{8'hA5}},  0, 0, 1'b0};
    vecs[2] = '{0, 1, 32'h0,         32'hDEAD_BEEF, {8{16'hBEEF}}, 5, 3, 1'b1};
    vecs[3] = '{1, 1, 32'h0000_4448, 32'h0000_8881, {4{32'h1234_5678}}, 1, 0, tie(1'b0)};
    vecs[4] = '{1, 1, 32'h0000_AAA5, 32'h0000_BBB6, {4{32'h8765_4321}}, 0, 1, tie(1'b1)};
    vecs[5] = '{1, 0, 32'hFFFF_FFFF, 32'h0,         {128{1'b1}},  2, 0, 1'b0};
    vecs[6] = '{0, 1, 32'h0,         32'h0000_000F, 128'h1,       0, 0, 1'b1};
    vecs[7] = '{1, 1, 32'h7000_0003, 32'h8000_0004, {2{64'hCAFE_F00D_0BAD_BEEF}}, 0, 2, tie(1'b0)};

    resetn = 1'b0;
    bus.ic_arvalid = 1'b1; bus.dc_arvalid = 1'b1;
    bus.ic_araddr  = 32'h1000_0044; bus.dc_araddr = 32'h2000_0088;
    bus.ic_rready  = 1'b0; bus.dc_rready = 1'b0;
    bus.ARREADY    = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", bus.ARVALID, 1'b0);
    chk("rst_araddr", bus.ARADDR, 32'h0);
    chk("rst_rready", bus.RREADY, 1'b0);
    chk("rst_ic_arready", bus.ic_arready, 1'b0);
    chk("rst_dc_arready", bus.dc_arready, 1'b0);
    chk("rst_rvalid", bus.ic_rvalid | bus.dc_rvalid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant_dc", bus.grant_dc, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Tie right after reset, loser keeps requesting and is granted in the next IDLE cycle
    w = tie(1'b0);
    a = w ? bus.dc_araddr : bus.ic_araddr;
    grant_check(w, a & MASK, {16{8'h3C}});
    addr_phase(0, a & MASK);
    data_phase(w, 0, {16{8'h3C}});
    a = w ? bus.ic_araddr : bus.dc_araddr;
    grant_check(!w, a & MASK, {16{8'hC3}});
    addr_phase(0, a & MASK);
    data_phase(!w, 0, {16{8'hC3}});

    for (int i = 0; i < 8; i++) begin
      bus.ic_arvalid = vecs[i].ic_req;
      bus.dc_arvalid = vecs[i].dc_req;
      bus.ic_araddr  = vecs[i].ic_addr;
      bus.dc_araddr  = vecs[i].dc_addr;
      a = (vecs[i].exp_gdc ? vecs[i].dc_addr : vecs[i].ic_addr) & MASK;
      grant_check(vecs[i].exp_gdc, a, vecs[i].rd);
      bus.ic_arvalid = 1'b0;
      bus.dc_arvalid = 1'b0;
      addr_phase(vecs[i].ar_dly, a);
      data_phase(vecs[i].exp_gdc, vecs[i].r_dly, vecs[i].rd);
    end

    // Reset in the middle of DATA drops the transaction
    bus.dc_arvalid = 1'b1;
    bus.dc_araddr  = 32'h3000_0017;
    grant_check(1'b1, 32'h3000_0010, {16{8'h77}});
    addr_phase(0, 32'h3000_0010);
    bus.dc_rready = 1'b1;
    @(negedge clk);
    chk("pre_rst_rready", bus.RREADY, 1'b1);
    chk("pre_rst_busy", bus.busy, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_arvalid", bus.ARVALID, 1'b0);
    chk("midrst_rready", bus.RREADY, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_grant_dc", bus.grant_dc, 1'b1);
    chk("midrst_araddr", bus.ARADDR, 32'h0);
    void'(sb_q.pop_back());
    bus.dc_rready = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    bus.ic_arvalid = 1'b1; bus.dc_arvalid = 1'b1;
    bus.ic_araddr  = 32'h0000_0104; bus.dc_araddr = 32'h0000_0208;
    w = tie(1'b0);
    a = (w ? 32'h0000_0208 : 32'h0000_0104) & MASK;
    grant_check(w, a, {16{8'h99}});
    bus.ic_arvalid = 1'b0; bus.dc_arvalid = 1'b0;
    addr_phase(0, a);
    data_phase(w, 0, {16{8'h99}});

    repeat (2) @(posedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
